warp_scheduler: RTL and testbench
=================================

// Module: warp_scheduler
// PURPOSE
//  Parametrised successor to the single-thread Scheduler: holds NUM_WARPS independent PCs, picks one
//  ready warp per issue slot round-robin, fetches from the synchronous InstructionMemory, decodes
//  {opcode,x,y,z,I} and presents it to the SM core with a valid/ready handshake.
//  Adds warp launch, HALT retirement, branch redirect and back-pressure.
// PARAMETERS
//  NUM_WARPS     4    warps tracked; power of two, >=2
//  WARP_W        2    log2(NUM_WARPS)
//  ADDR_WIDTH    8    instruction address width (INSTMEM_ADDR_WIDTH)
//  OP_W          4    opcode field width
//  REG_W         4    width of x, y, z register index fields
//  IMM_W         16   immediate field width
//  INST_LENGTH   32   OP_W+3*REG_W+IMM_W; layout inst = {op, x, y, z, I}, op in MSBs
//  OP_HALT       4'hF opcode retiring the issuing warp
//  OP_BRA        4'hE opcode: next PC = I[ADDR_WIDTH-1:0]
// PORTS
//  clk           in   1            rising-edge clock
//  reset         in   1            asynchronous, active-high reset
//  launch_valid  in   1            request to start a warp
//  launch_warp   in   WARP_W       warp to start
//  launch_pc     in   ADDR_WIDTH   start PC for that warp
//  launch_ready  out  1            1 when launch_warp is IDLE or DONE
//  inst_addr     out  ADDR_WIDTH   fetch address to InstructionMemory
//  inst          in   INST_LENGTH  fetched word, valid 1 cycle after inst_addr is driven
//  out_valid     out  1            decoded instruction valid
//  out_ready     in   1            core accepts decoded instruction
//  out_warp      out  WARP_W       warp owning the issued instruction
//  opcode        out  OP_W         decoded opcode
//  x, y, z       out  REG_W        decoded register indices
//  I             out  IMM_W        decoded immediate
//  warp_done     out  NUM_WARPS    per-warp sticky DONE flag
//  busy          out  1            any warp ACTIVE or FSM not in S_IDLE
// BEHAVIOUR
//  Reset: all warps IDLE, PCs 0, inst_addr 0, out_valid 0, out_warp/opcode/x/y/z/I 0, warp_done 0,
//   rr pointer 0, FSM S_IDLE. Reset mid-instruction drops it; no pending state survives.
//  Per-warp state: IDLE -> ACTIVE on accepted launch (launch_valid & launch_ready); PC <= launch_pc.
//   ACTIVE -> DONE on issue handshake of OP_HALT. DONE -> ACTIVE on relaunch (clears warp_done bit).
//   Launch of an ACTIVE warp: launch_ready=0, request ignored.
//  FSM: S_IDLE: if any ACTIVE warp, select first ACTIVE at or after rr pointer (wrapping), latch sel,
//   drive inst_addr=PC[sel], -> S_FETCH.  S_FETCH: memory read in flight, -> S_DECODE.
//   S_DECODE: register fields of inst into outputs, out_valid<=1, -> S_ISSUE.
//   S_ISSUE: hold all outputs stable while out_valid & !out_ready. On handshake: out_valid<=0;
//   PC[sel] <= OP_BRA ? I[ADDR_WIDTH-1:0] : PC[sel]+1 (wraps modulo 2^ADDR_WIDTH, no flag);
//   OP_HALT: PC unchanged, warp -> DONE; rr <= sel+1 mod NUM_WARPS; -> S_IDLE.
//  Latency: warp selection to out_valid = 3 cycles; max one issue every 4 cycles with out_ready=1.
//  Launch of the warp currently in flight (sel) is blocked: launch_ready=0 while FSM!=S_IDLE and
//   launch_warp==sel. Launches to other warps are accepted in any FSM state and join arbitration next cycle.
//  Launch accepted in S_IDLE in the same cycle as selection: new warp is not visible until next cycle.
//  No ACTIVE warps: FSM stays S_IDLE, inst_addr holds last value, busy=0 once all warps IDLE/DONE.
// TESTING
//  T1 reset 3 cycles, then idle 10 -> out_valid=0, busy=0, inst_addr=0, warp_done=0.
//  T2 launch warp0 pc=0, mem[0..2]=ADD,ADD,HALT, out_ready=1 -> three issues 4 cycles apart,
//     out_warp=0, fields match mem, warp_done=4'b0001, busy drops.
//  T3 launch warps 0..3 pc=0x10,0x20,0x30,0x40 -> issue order warp 0,1,2,3,0,..., addrs 0x10,0x20,0x30,0x40,0x11.
//  T4 out_ready=0 for 5 cycles in S_ISSUE -> outputs stable, no PC advance; release -> single issue.
//  T5 OP_BRA I=0x05 at pc=0xFF, then plain inst at 0xFF for other warp -> branch warp next fetch 0x05;
//     other warp wraps to 0x00.
//  T6 assert reset during S_FETCH and during stalled S_ISSUE -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/warp_scheduler_if.sv
// Warp scheduler bus: launch, fetch and issue signals.
// master = scheduler side, slave = core/memory/launcher side.
interface warp_scheduler_if #(
  parameter int NUM_WARPS   = 4,
  parameter int WARP_W      = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int OP_W        = 4,
  parameter int REG_W       = 4,
  parameter int IMM_W       = 16,
  parameter int INST_LENGTH = 32
) ();
  logic                   launch_valid;
  logic [WARP_W-1:0]      launch_warp;
  logic [ADDR_WIDTH-1:0]  launch_pc;
  logic                   launch_ready;
  logic [ADDR_WIDTH-1:0]  inst_addr;
  logic [INST_LENGTH-1:0] inst;
  logic                   out_valid;
  logic                   out_ready;
  logic [WARP_W-1:0]      out_warp;
  logic [OP_W-1:0]        opcode;
  logic [REG_W-1:0]       x;
  logic [REG_W-1:0]       y;
  logic [REG_W-1:0]       z;
  logic [IMM_W-1:0]       I;
  logic [NUM_WARPS-1:0]   warp_done;
  logic                   busy;

  modport master (
    input  launch_valid, launch_warp, launch_pc,
    input  inst, out_ready,
    output launch_ready, inst_addr, out_valid,
    output out_warp, opcode, x, y, z, I,
    output warp_done, busy
  );

  modport slave (
    output launch_valid, launch_warp, launch_pc,
    output inst, out_ready,
    input  launch_ready, inst_addr, out_valid,
    input  out_warp, opcode, x, y, z, I,
    input  warp_done, busy
  );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin multi-warp fetch/decode/issue scheduler.
// Ports: clk, reset (async high), bus (warp_scheduler_if.master).
module warp_scheduler #(
  parameter int NUM_WARPS   = 4,
  parameter int WARP_W      = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int OP_W        = 4,
  parameter int REG_W       = 4,
  parameter int IMM_W       = 16,
  parameter int INST_LENGTH = OP_W + 3*REG_W + IMM_W,
  parameter logic [OP_W-1:0] OP_HALT = 4'hF,
  parameter logic [OP_W-1:0] OP_BRA  = 4'hE
) (
  input logic clk,
  input logic reset,
  warp_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE
  } fsm_e;

  typedef enum logic [1:0] {
    W_IDLE, W_ACTIVE, W_DONE
  } wst_e;

  localparam int X_HI = INST_LENGTH - OP_W - 1;
  localparam int Y_HI = X_HI - REG_W;
  localparam int Z_HI = Y_HI - REG_W;

  fsm_e                  state_q;
  wst_e                  wst_q [NUM_WARPS];
  logic [ADDR_WIDTH-1:0] pc_q  [NUM_WARPS];
  logic [WARP_W-1:0]     rr_q;
  logic [WARP_W-1:0]     sel_q;
  logic [ADDR_WIDTH-1:0] inst_addr_q;
  logic                  out_valid_q;
  logic [WARP_W-1:0]     out_warp_q;
  logic [OP_W-1:0]       opcode_q;
  logic [REG_W-1:0]      x_q;
  logic [REG_W-1:0]      y_q;
  logic [REG_W-1:0]      z_q;
  logic [IMM_W-1:0]      i_q;

  logic [NUM_WARPS-1:0]  active;
  logic [NUM_WARPS-1:0]  done;
  logic                  pick_ok;
  logic [WARP_W-1:0]     pick_idx;
  logic                  launch_rdy;
  logic                  launch_acc;

  always_comb begin
    active = '0;
    done   = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      active[k] = (wst_q[k] == W_ACTIVE);
      done[k]   = (wst_q[k] == W_DONE);
    end
  end

  // Scan offsets high to low so the
  // closest warp at/after rr wins.
  always_comb begin
    logic [WARP_W-1:0] idx;
    idx      = '0;
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int k = NUM_WARPS-1; k >= 0; k--) begin
      idx = rr_q + WARP_W'(k);
      if (active[idx]) begin
        pick_ok  = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // The in-flight warp cannot be
  // relaunched until it leaves the pipe.
  always_comb begin
    launch_rdy = (wst_q[bus.launch_warp] != W_ACTIVE)
      && !((state_q != S_IDLE)
      && (bus.launch_warp == sel_q));
    launch_acc = bus.launch_valid & launch_rdy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      inst_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_warp_q  <= '0;
      opcode_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      for (int k = 0; k < NUM_WARPS; k++) begin
        wst_q[k] <= W_IDLE;
        pc_q[k]  <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_ok) begin
            sel_q       <= pick_idx;
            inst_addr_q <= pc_q[pick_idx];
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          out_warp_q  <= sel_q;
          opcode_q    <= bus.inst[INST_LENGTH-1 -: OP_W];
          x_q         <= bus.inst[X_HI -: REG_W];
          y_q         <= bus.inst[Y_HI -: REG_W];
          z_q         <= bus.inst[Z_HI -: REG_W];
          i_q         <= bus.inst[IMM_W-1:0];
          out_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (opcode_q == OP_HALT) begin
              wst_q[sel_q] <= W_DONE;
            end else if (opcode_q == OP_BRA) begin
              pc_q[sel_q] <= i_q[ADDR_WIDTH-1:0];
            end else begin
              pc_q[sel_q] <= pc_q[sel_q]
                + ADDR_WIDTH'(1);
            end
            rr_q    <= sel_q + WARP_W'(1);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Never targets sel_q while in flight,
      // so it cannot collide with the update above.
      if (launch_acc) begin
        wst_q[bus.launch_warp] <= W_ACTIVE;
        pc_q[bus.launch_warp]  <= bus.launch_pc;
      end
    end
  end

  assign bus.launch_ready = launch_rdy;
  assign bus.inst_addr    = inst_addr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_warp     = out_warp_q;
  assign bus.opcode       = opcode_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.z            = z_q;
  assign bus.I            = i_q;
  assign bus.warp_done    = done;
  assign bus.busy         = (|active)
    || (state_q != S_IDLE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: directed scenarios
// plus random traffic against a per-warp model.
module tb_warp_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  warp_scheduler_if bus ();

  warp_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  always @(posedge clk) bus.inst <= mem[bus.inst_addr];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // model: warp status 0=idle 1=active 2=done
  int          m_wst [4];
  logic [7:0]  m_pc  [4];
  int          m_rr;
  bit          m_fl;
  int          m_sel;
  int          m_cnt;
  bit          m_ov;
  logic [7:0]  m_addr;
  logic [31:0] m_word;

  logic [7:0] la_q [$];
  int         lw_q [$];
  int         lc_q [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [3:0] op, input logic [3:0] a,
    input logic [3:0] b, input logic [3:0] c,
    input logic [15:0] imm);
    return {op, a, b, c, imm};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_wst[k] = 0;
      m_pc[k]  = 8'h00;
    end
    m_rr = 0; m_fl = 0; m_sel = 0;
    m_cnt = 0; m_ov = 0;
    m_addr = 8'h00; m_word = 32'h0;
  endtask

  task automatic check_outputs();
    logic [3:0] wd;
    bit bz;
    wd = 4'h0;
    bz = m_fl;
    for (int k = 0; k < 4; k++) begin
      if (m_wst[k] == 2) wd[k] = 1'b1;
      if (m_wst[k] == 1) bz = 1'b1;
    end
    chk("out_valid", bus.out_valid, m_ov);
    chk("busy", bus.busy, bz);
    chk("inst_addr", bus.inst_addr, m_addr);
    chk("warp_done", bus.warp_done, wd);
    if (m_ov) begin
      chk("out_warp", bus.out_warp, m_sel);
      chk("opcode", bus.opcode, m_word[31:28]);
      chk("x", bus.x, m_word[27:24]);
      chk("y", bus.y, m_word[23:20]);
      chk("z", bus.z, m_word[19:16]);
      chk("I", bus.I, m_word[15:0]);
    end
  endtask

  task automatic step(input bit lv, input int lw,
                      input logic [7:0] lpc,
                      input bit ordy);
    bit lr, acc, hs, found;
    int w;
    logic [3:0] op;
    lr  = (m_wst[lw] != 1) && !(m_fl && lw == m_sel);
    chk("launch_ready", bus.launch_ready, lr);
    acc = lv && lr;
    hs  = m_ov && ordy;
    if (hs) begin
      la_q.push_back(bus.inst_addr);
      lw_q.push_back(int'(bus.out_warp));
      lc_q.push_back(cycle);
    end
    if (!m_fl) begin
      found = 0; w = 0;
      for (int o = 0; o < 4; o++) begin
        if (!found && m_wst[(m_rr + o) % 4] == 1) begin
          found = 1;
          w = (m_rr + o) % 4;
        end
      end
      if (found) begin
        m_fl = 1; m_sel = w; m_cnt = 1;
        m_addr = m_pc[w];
        m_word = mem[m_pc[w]];
      end
    end else if (hs) begin
      op = m_word[31:28];
      if (op == 4'hF)
        m_wst[m_sel] = 2;
      else if (op == 4'hE)
        m_pc[m_sel] = m_word[7:0];
      else
        m_pc[m_sel] = m_pc[m_sel] + 8'h01;
      m_rr = (m_sel + 1) % 4;
      m_fl = 0; m_ov = 0;
    end else if (!m_ov) begin
      m_cnt++;
      if (m_cnt == 3) m_ov = 1;
    end
    if (acc) begin
      m_wst[lw] = 1;
      m_pc[lw]  = lpc;
    end
  endtask

  task automatic cyc(input bit lv, input int lw,
                     input int lpc, input bit ordy);
    logic [1:0] w2;
    logic [7:0] p8;
    w2 = lw[1:0];
    p8 = lpc[7:0];
    bus.launch_valid = lv;
    bus.launch_warp  = w2;
    bus.launch_pc    = p8;
    bus.out_ready    = ordy;
    #1;
    step(lv, int'(w2), p8, ordy);
    @(negedge clk);
    cycle++;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.launch_valid = 1'b0;
    bus.launch_warp  = 2'd0;
    bus.launch_pc    = 8'h00;
    bus.out_ready    = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_out_warp", bus.out_warp, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_xyz", {bus.x, bus.y, bus.z}, 0);
    chk("rst_I", bus.I, 0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    la_q.delete(); lw_q.delete(); lc_q.delete();
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cyc(0, 0, 0, r);
  endtask

  initial begin
    logic [7:0] ea [5];
    int ew [5];
    int r;
    bus.launch_valid = 1'b0;
    bus.launch_warp  = 2'd0;
    bus.launch_pc    = 8'h00;
    bus.out_ready    = 1'b0;
    for (int k = 0; k < 256; k++)
      mem[k] = mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0000);

    // T1: reset, idle
    do_reset(3);
    idle(10, 1'b0);
    chk("t1_valid", bus.out_valid, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_addr", bus.inst_addr, 8'h00);
    chk("t1_done", bus.warp_done, 4'h0);

    // T2: single warp, ADD ADD HALT
    mem[0] = mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0011);
    mem[1] = mk(4'h1, 4'h4, 4'h5, 4'h6, 16'h0022);
    mem[2] = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    do_reset(2);
    clear_log();
    cyc(1, 0, 0, 1);
    idle(20, 1'b1);
    chk("t2_n", la_q.size(), 3);
    if (la_q.size() >= 3) begin
      chk("t2_a0", la_q[0], 8'h00);
      chk("t2_a1", la_q[1], 8'h01);
      chk("t2_a2", la_q[2], 8'h02);
      chk("t2_w", lw_q[0] + lw_q[1] + lw_q[2], 0);
      chk("t2_gap1", lc_q[1] - lc_q[0], 4);
      chk("t2_gap2", lc_q[2] - lc_q[1], 4);
    end
    chk("t2_done", bus.warp_done, 4'b0001);
    chk("t2_busy", bus.busy, 0);

    // T3: four warps round-robin
    do_reset(2);
    clear_log();
    cyc(1, 0, 8'h10, 1);
    cyc(1, 1, 8'h20, 1);
    cyc(1, 2, 8'h30, 1);
    cyc(1, 3, 8'h40, 1);
    idle(30, 1'b1);
    ea[0] = 8'h10; ea[1] = 8'h20; ea[2] = 8'h30;
    ea[3] = 8'h40; ea[4] = 8'h11;
    ew[0] = 0; ew[1] = 1; ew[2] = 2;
    ew[3] = 3; ew[4] = 0;
    chk("t3_n", la_q.size() >= 5, 1);
    if (la_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t3_addr", la_q[k], ea[k]);
        chk("t3_warp", lw_q[k], ew[k]);
      end
    end

    // T4: back-pressure
    mem[8'h50] = mk(4'h2, 4'h7, 4'h8, 4'h9, 16'hBEEF);
    mem[8'h51] = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    do_reset(2);
    clear_log();
    cyc(1, 1, 8'h50, 0);
    idle(8, 1'b0);
    chk("t4_valid", bus.out_valid, 1);
    chk("t4_addr", bus.inst_addr, 8'h50);
    chk("t4_I", bus.I, 16'hBEEF);
    chk("t4_nolog", la_q.size(), 0);
    cyc(0, 0, 0, 1);
    chk("t4_drop", bus.out_valid, 0);
    chk("t4_one", la_q.size(), 1);
    idle(10, 1'b1);
    chk("t4_n", la_q.size(), 2);
    if (la_q.size() >= 2)
      chk("t4_next", la_q[1], 8'h51);
    chk("t4_done", bus.warp_done, 4'b0010);

    // T5: branch and PC wrap
    mem[8'hFF] = mk(4'hE, 4'h0, 4'h0, 4'h0, 16'h0005);
    mem[8'h05] = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    mem[8'h00] = mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    do_reset(2);
    clear_log();
    cyc(1, 2, 8'hFF, 1);
    idle(12, 1'b1);
    mem[8'hFF] = mk(4'h1, 4'h1, 4'h1, 4'h1, 16'h0000);
    cyc(1, 3, 8'hFF, 1);
    idle(12, 1'b1);
    chk("t5_n", la_q.size(), 4);
    if (la_q.size() >= 4) begin
      chk("t5_bra", la_q[0], 8'hFF);
      chk("t5_tgt", la_q[1], 8'h05);
      chk("t5_pl", la_q[2], 8'hFF);
      chk("t5_wrap", la_q[3], 8'h00);
      chk("t5_w", lw_q[3], 3);
    end
    chk("t5_done", bus.warp_done, 4'b1100);

    // T6: reset mid-flight
    mem[8'h00] = mk(4'h1, 4'h0, 4'h0, 4'h0, 16'h0000);
    do_reset(2);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_busy", bus.busy, 1);
    do_reset(1);
    cyc(1, 1, 8'h50, 0);
    idle(6, 1'b0);
    chk("t6_stall", bus.out_valid, 1);
    do_reset(1);
    idle(5, 1'b1);
    chk("t6_idle", bus.busy, 0);

    // random traffic
    for (int k = 0; k < 256; k++) begin
      r = int'($urandom % 8);
      mem[k] = {
        r == 0 ? 4'hF :
        r == 1 ? 4'hE :
        4'($urandom % 14),
        12'($urandom), 16'($urandom)};
    end
    do_reset(2);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 700 == 0) begin
        do_reset(1);
      end else begin
        cyc(($urandom % 4) == 0,
            int'($urandom % 4),
            int'($urandom % 256),
            ($urandom % 3) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
